scan_chain_ctrl: RTL and testbench



---
 rtl/scan_ctrl_pkg.sv | 15 +
 rtl/scan_shift_reg.sv | 25 ++
 rtl/scan_chain_ctrl.sv | 153 +++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared state encoding for the scan chain controller.
// The VERIFY encoding is only reachable when SCAN_CTRL_VERIFY_EN is defined.
package scan_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_UPDATE = 3'd2,
    ST_DONE   = 3'd3,
    ST_VERIFY = 3'd4
  } state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load, right-shift register with serial input at the MSB.
// Load wins over shift; serial output is q[0].
module scan_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {ser_in, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Serial configuration sequencer for a CHAIN_LEN-stage scan chain: shift in, update, read back.
// Define SCAN_CTRL_VERIFY_EN to add a re-circulating VERIFY pass that drives err.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] load_data,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] read_data,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 update,
  output logic                 err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] shreg;
  logic                 sh_load;
  logic                 sh_shift;
  logic [CHAIN_LEN-1:0] sh_load_val;
  logic                 accept;

  assign accept  = (state == ST_IDLE) && start;
  assign scan_in = shreg[0];

`ifdef SCAN_CTRL_VERIFY_EN
  logic [CHAIN_LEN-1:0] saved;
  logic                 mismatch;
  logic                 err_acc;
  logic                 err_q;

  // The saved copy rotates through VERIFY so saved[0] tracks the bit due on scan_out.
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_saved (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (load_data),
    .shift    (state == ST_VERIFY),
    .ser_in   (saved[0]),
    .q        (saved)
  );

  assign mismatch = (state == ST_VERIFY) && (scan_out != saved[0]);
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    sh_load     = accept;
    sh_load_val = load_data;
    sh_shift    = (state == ST_SHIFT);
`ifdef SCAN_CTRL_VERIFY_EN
    if (state == ST_UPDATE) begin
      sh_load     = 1'b1;
      sh_load_val = saved;
    end
    sh_shift = (state == ST_SHIFT) || (state == ST_VERIFY);
`endif
  end

  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sh_load),
    .load_val (sh_load_val),
    .shift    (sh_shift),
    .ser_in   (scan_out),
    .q        (shreg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      read_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      scan_en   <= 1'b0;
      update    <= 1'b0;
`ifdef SCAN_CTRL_VERIFY_EN
      err_q     <= 1'b0;
      err_acc   <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      update <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt     <= '0;
            busy    <= 1'b1;
            scan_en <= 1'b1;
            state   <= ST_SHIFT;
`ifdef SCAN_CTRL_VERIFY_EN
            err_q   <= 1'b0;
            err_acc <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            scan_en <= 1'b0;
            update  <= 1'b1;
            state   <= ST_UPDATE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_UPDATE: begin
          read_data <= shreg;
`ifdef SCAN_CTRL_VERIFY_EN
          scan_en   <= 1'b1;
          state     <= ST_VERIFY;
`else
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= ST_DONE;
`endif
        end
`ifdef SCAN_CTRL_VERIFY_EN
        ST_VERIFY: begin
          if (mismatch) err_acc <= 1'b1;
          if (cnt == LAST) begin
            cnt     <= '0;
            scan_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            err_q   <= err_acc | mismatch;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an 8-stage mux+dff chain model on the serial pins.
// Define SCAN_CTRL_VERIFY_EN to also exercise the verify pass and a stuck-at-0 stage.
module tb_scan_chain_ctrl;

  localparam int N = 8;
`ifdef SCAN_CTRL_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int DONE_K = VER ? 2 * N + 2 : N + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] load_data = '0;
  logic         busy, done, scan_en, scan_in, scan_out, update, err;
  logic [N-1:0] read_data;

  logic [N-1:0] chain = '0;
  logic         stuck = 1'b0;
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  logic [N-1:0] exp_q[$];

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .load_data (load_data),
    .busy      (busy),
    .done      (done),
    .read_data (read_data),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
    .update    (update),
    .err       (err)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain model: stage 0 takes scan_in, scan_out is the last stage; stage 3 may be stuck at 0.
  always @(posedge clk)
    if (scan_en) chain <= {chain[N-2:0], scan_in} & (stuck ? 8'hF7 : 8'hFF);
  assign scan_out = chain[N-1];

  function automatic logic [N-1:0] rev(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) rev[i] = v[N-1-i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: one full load transaction, checking control timing every cycle.
  task automatic do_op(input logic [N-1:0] word, input bit guard, input bit exp_err,
                       output int done_cyc);
    logic [N-1:0] sin_bits;
    sin_bits = '0;
    done_cyc = 0;
    @(negedge clk);
    start     = 1'b1;
    load_data = word;
    // Stages 0..3 must pass the stuck stage on their way out, so only stages 4..7 survive.
    exp_q.push_back(rev(chain & (stuck ? 8'hF0 : 8'hFF)));
    for (int k = 1; k <= DONE_K; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (guard && k == 3) begin start = 1'b1; load_data = '1; end
      if (guard && k == 4) start = 1'b0;
      if (k <= N) sin_bits[k-1] = scan_in;
      chk("ctl{busy,scan_en,update,done}", {busy, scan_en, update, done},
          {k < DONE_K, (k <= N) || (VER && k >= N + 2 && k <= 2 * N + 1), k == N + 1, k == DONE_K});
      if (k == DONE_K) begin
        done_cyc = cyc;
        chk("err_at_done", err, exp_err);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL sb_empty: got no expected entry, expected one queued");
        end else begin
          chk("read_data", read_data, exp_q.pop_front());
        end
        if (guard) start = 1'b1;
      end
    end
    chk("scan_in_seq", sin_bits, word);
    if (guard) begin
      @(negedge clk);
      start = 1'b0;
      chk("guard_idle", {busy, dut.state}, 0);
      @(negedge clk);
      chk("guard_busy", {busy, scan_en}, 0);
    end
  endtask

  initial begin
    int d1, d2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_scan_en", scan_en, 0);
    chk("rst_update", update, 0);
    chk("rst_err", err, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_state", dut.state, 0);
    rst_n = 1'b1;

    do_op(8'hA5, 1'b0, 1'b0, d1);
    chk("chain_a5", rev(chain), 8'hA5);
    do_op(8'h3C, 1'b0, 1'b0, d1);
    chk("readback_a5", read_data, 8'hA5);
    chk("chain_3c", rev(chain), 8'h3C);

    do_op(8'h96, 1'b1, 1'b0, d1);
    chk("guard_chain", rev(chain), 8'h96);

    @(negedge clk);
    start     = 1'b1;
    load_data = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_scan_en", scan_en, 0);
    chk("mid_rst_read_data", read_data, 0);
    chk("mid_rst_state", dut.state, 0);
    rst_n = 1'b1;
    do_op(8'hC3, 1'b0, 1'b0, d1);
    chk("chain_c3", rev(chain), 8'hC3);

    do_op(8'h81, 1'b0, 1'b0, d1);
    do_op(8'h7E, 1'b0, 1'b0, d2);
    chk("b2b_gap", d2 - d1, DONE_K + 1);
    chk("readback_81", read_data, 8'h81);

`ifdef SCAN_CTRL_VERIFY_EN
    stuck = 1'b1;
    do_op(8'h5A, 1'b0, 1'b1, d1);
    @(negedge clk);
    chk("err_hold", err, 1);
    stuck = 1'b0;
    do_op(8'h5A, 1'b0, 1'b0, d1);
    chk("verify_chain_5a", rev(chain), 8'h5A);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
